// File: rtl/ext_w_packer.sv
// Write-data framing stage ahead of the external W-channel buffer: turns a burst command plus
// lane-aligned data words into registered AXI W beats. Optional sticky error flag: EXT_W_PACKER_ERR_EN.
module ext_w_packer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6,
  parameter int unsigned LEN_WIDTH  = 11,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned OFFS_WIDTH = $clog2(STRB_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [OFFS_WIDTH-1:0] cmd_offs_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [USER_WIDTH-1:0] cmd_user_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [STRB_WIDTH-1:0] master_strb_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
`ifdef EXT_W_PACKER_ERR_EN
  output logic                  err_o,
`endif
  output logic                  busy_o
);

  localparam int unsigned EndWidth  = LEN_WIDTH + 1;
  // One extra bit so the beat count of a maximum burst (256 plus offset spill) never wraps.
  localparam int unsigned BeatWidth = EndWidth - OFFS_WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q, state_d;
  logic [OFFS_WIDTH-1:0] offs_q;
  logic [OFFS_WIDTH-1:0] end_lo_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [BeatWidth-1:0]  beats_q;
  logic                  first_q;

  logic [EndWidth-1:0]   cmd_end;
  logic [BeatWidth-1:0]  cmd_beats;
  logic                  cmd_accept;
  logic                  load;
  logic                  out_free;
  logic                  last_beat;
  logic [STRB_WIDTH-1:0] strb_first;
  logic [STRB_WIDTH-1:0] strb_last;

  assign cmd_end   = EndWidth'(cmd_offs_i) + EndWidth'(cmd_len_i);
  assign cmd_beats = BeatWidth'(cmd_end >> OFFS_WIDTH) + BeatWidth'(1);
  assign last_beat = (beats_q == BeatWidth'(1));
  assign out_free  = !master_valid_o || master_ready_i;

  assign strb_first = first_q ? ({STRB_WIDTH{1'b1}} << offs_q) : {STRB_WIDTH{1'b1}};
  assign strb_last  = last_beat ?
                      ({STRB_WIDTH{1'b1}} >> (OFFS_WIDTH'(STRB_WIDTH - 1) - end_lo_q)) :
                      {STRB_WIDTH{1'b1}};

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    cmd_accept  = 1'b0;
    load        = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_accept = 1'b1;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        in_ready_o = out_free;
        if (in_valid_i && out_free) begin
          load = 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offs_q   <= '0;
      end_lo_q <= '0;
      user_q   <= '0;
      beats_q  <= '0;
      first_q  <= 1'b0;
    end else if (cmd_accept) begin
      offs_q   <= cmd_offs_i;
      end_lo_q <= cmd_end[OFFS_WIDTH-1:0];
      user_q   <= cmd_user_i;
      beats_q  <= cmd_beats;
      first_q  <= 1'b1;
    end else if (load) begin
      beats_q  <= beats_q - BeatWidth'(1);
      first_q  <= 1'b0;
    end
  end

  // Output register: payload only changes on a load, so it is stable while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      master_valid_o <= 1'b0;
      master_data_o  <= '0;
      master_strb_o  <= '0;
      master_user_o  <= '0;
      master_last_o  <= 1'b0;
    end else if (load) begin
      master_valid_o <= 1'b1;
      master_data_o  <= in_data_i;
      master_strb_o  <= strb_first & strb_last;
      master_user_o  <= user_q;
      master_last_o  <= last_beat;
    end else if (master_ready_i) begin
      master_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_q == StBurst) || master_valid_o;

`ifdef EXT_W_PACKER_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == StIdle && in_valid_i) ||
                 (cmd_accept && (32'(cmd_beats) > 32'd256))) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`endif

endmodule

// File: doc/ext_w_packer.md
Name: ext_w_packer

Overview:
- Write-data framing stage directly upstream of the external W-channel buffer in the mchan ext unit.
- Consumes one burst command per AXI write burst: byte offset of first byte within a bus word, byte length minus one, and user bits.
- Consumes a stream of lane-aligned data words and emits AXI W beats with computed byte strobes, user bits and last flag.
- Output is registered, so it drives the buffer with no combinational path from master_ready_i to any master_* output.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; power of two, at least 16.
- USER_WIDTH, 6, user sideband width.
- LEN_WIDTH, 11, width of cmd_len_i. Length field is bytes minus 1, so the maximum burst is 2048 bytes (256 beats at 64 bits).
- STRB_WIDTH, DATA_WIDTH/8, derived; do not override.
- OFFS_WIDTH, log2(STRB_WIDTH), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_offs_i  in  OFFS_WIDTH  byte lane of the first byte.
- cmd_len_i  in  LEN_WIDTH  byte count minus 1.
- cmd_user_i  in  USER_WIDTH  user bits applied to every beat of the burst.
- in_valid_i  in  1  data word valid.
- in_data_i  in  DATA_WIDTH  lane-aligned data word.
- in_ready_o  out  1  data word accepted.
- master_valid_o  out  1  W beat valid.
- master_data_o  out  DATA_WIDTH  W data.
- master_strb_o  out  STRB_WIDTH  W byte strobes.
- master_user_o  out  USER_WIDTH  W user bits.
- master_last_o  out  1  last beat of the burst.
- master_ready_i  in  1  downstream ready.
- busy_o  out  1  high while state is BURST or master_valid_o is high.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - Counters and latched fields = 0.
  - master_valid_o, master_last_o = 0; master_data_o, master_strb_o, master_user_o = 0.
- State IDLE:
  - cmd_ready_o = 1, in_ready_o = 0.
  - On cmd_valid_i: latch offs, user, end = offs + len (LEN_WIDTH+1 bits), beats_left = (end >> OFFS_WIDTH) + 1, first = 1; go to BURST.
- State BURST:
  - cmd_ready_o = 0.
  - in_ready_o = !master_valid_o || master_ready_i.
  - On an in_valid_i && in_ready_o handshake, the output register loads on the next edge:
    - data = in_data_i.
    - user = latched user.
    - strb = S_first AND S_last, where S_first = all-ones << offs if first else all-ones, and S_last = all-ones >> (STRB_WIDTH-1 - end[OFFS_WIDTH-1:0]) if beats_left == 1 else all-ones.
    - last = (beats_left == 1).
    - beats_left decrements; first clears.
  - When the beat with last = 1 is loaded, return to IDLE.
- Output register:
  - When no load occurs, master_valid_o clears on master_ready_i.
  - All master_* outputs are held stable while master_valid_o && !master_ready_i.
- Latency and throughput:
  - Data in to beat out: 1 cycle.
  - Full throughput is one beat per cycle under continuous ready.
  - One command is accepted per IDLE visit, which costs at least a 1-cycle bubble between bursts (command accepted in the cycle after last-beat acceptance).
- Boundary conditions:
  - A single-beat burst yields first and last on the same beat.
  - end = STRB_WIDTH*256 - 1 (maximum) yields 256 beats with no counter wrap.
  - in_valid_i while IDLE is ignored; in_ready_o = 0.
  - Reset mid-burst drops the burst and the held beat; there is no partial completion.

Optional Feature:
- Macro: EXT_W_PACKER_ERR_EN.
- When defined:
  - Adds output err_o (1 bit), reset 0, sticky until reset.
  - Sets on in_valid_i while IDLE.
  - Sets on command acceptance with beat count > 256.
  - Behaviour is otherwise unchanged.
- When undefined: err_o and its logic are absent.

Test Plan:
- cmd offs=3, len=9, two data words, ready=1 -> beat0 strb 0xF8, last 0; beat1 strb 0x1F, last 1; each 1 cycle after its input.
- cmd offs=0, len=7 -> single beat, strb 0xFF, last 1; state back to IDLE; cmd_ready_o = 1 the following cycle.
- cmd offs=2, len=2 -> single beat, strb 0x1C, last 1.
- cmd offs=0, len=2047, continuous data -> 256 beats, all strb 0xFF, last only on beat 256, no idle cycles.
- Mid-burst master_ready_i low for 5 cycles -> master_* held stable, in_ready_o = 0; burst resumes with no lost or duplicated beats.
- rst_ni low mid-burst -> all outputs zero asynchronously; new cmd offs=4, len=3 after release -> single beat, strb 0xF0, correct.
